// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the byte-lane helper
// used by the SRAM responder.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  // Address-phase snapshot carried into the data phase.
  typedef struct packed {
    logic       act;
    logic       wr;
    logic [1:0] size;
    logic [1:0] lane;
  } dphase_t;

  // Byte lanes touched by an aligned transfer (little-endian).
  function automatic logic [3:0] byte_en(logic [1:0] size, logic [1:0] lane);
    case (size)
      2'd0:    byte_en = 4'b0001 << lane;
      2'd1:    byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between a master and the SRAM responder.
interface ahb_lite_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_sram_slave_sram_array.sv
// Word array split into byte lanes, each with its own write enable;
// reads are combinational so data is available in the completing cycle.
module ahb_sram_array #(
  parameter int NUM_WORDS = 256,
  parameter int NUM_LANES = 4,
  localparam int AW = $clog2(NUM_WORDS)
) (
  input  logic                       clk,
  input  logic [NUM_LANES-1:0]       i_we,
  input  logic [AW-1:0]              i_waddr,
  input  logic [NUM_LANES-1:0][7:0]  i_wdata,
  input  logic [AW-1:0]              i_raddr,
  output logic [NUM_LANES-1:0][7:0]  o_rdata
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [7:0] r_mem [NUM_WORDS];

    always_ff @(posedge clk) begin
      if (i_we[g]) r_mem[i_waddr] <= i_wdata[g];
    end

    assign o_rdata[g] = r_mem[i_raddr];
  end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: address-phase decode, wait-state insertion and
// two-cycle ERROR response in front of a byte-lane SRAM array.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int          MEM_WORDS   = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic     HCLK,
  input  logic     HRESETn,
  ahb_lite_if.slave bus
);

  localparam int          AW   = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * MEM_WORDS);
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  state_e          r_state, w_state_nxt;
  logic [3:0]      r_cnt;
  dphase_t         r_dp;
  logic [AW-1:0]   r_widx;

  logic [31:0]     w_off;
  logic            w_hreadyout, w_hresp;
  logic            w_accept, w_err_in, w_ok, w_bad, w_done;
  logic [3:0]      w_we;
  logic [31:0]     w_rdata;
  logic            w_unused;

  assign w_off    = bus.HADDR - BASE_ADDR;
  assign w_err_in = (w_off >= SPAN) || (bus.HSIZE > 3'd2)
                 || (bus.HSIZE == 3'd1 && bus.HADDR[0])
                 || (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00);
  assign w_accept = bus.HSEL && bus.HREADY && bus.HTRANS[1] && w_hreadyout;
  assign w_ok     = w_accept && !w_err_in;
  assign w_bad    = w_accept && w_err_in;
  // Only an OKAY transfer has a pending data phase; it ends on the first ready cycle.
  assign w_done   = r_dp.act && w_hreadyout;
  assign w_unused = ^{bus.HBURST, bus.HPROT};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        if (w_bad)                   w_state_nxt = ST_ERR1;
        else if (w_ok && WS != 4'd0) w_state_nxt = ST_WAIT;
        else                         w_state_nxt = ST_IDLE;
      end
      ST_WAIT: if (r_cnt <= 4'd1) w_state_nxt = ST_IDLE;
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_hreadyout = 1'b1;
    w_hresp     = HRESP_OKAY;
    case (r_state)
      ST_WAIT: w_hreadyout = 1'b0;
      ST_ERR1: begin w_hreadyout = 1'b0; w_hresp = HRESP_ERROR; end
      ST_ERR2: w_hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                    r_cnt <= 4'd0;
    else if (w_ok && WS != 4'd0)     r_cnt <= WS;
    else if (r_state == ST_WAIT)     r_cnt <= r_cnt - 4'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp   <= '0;
      r_widx <= '0;
    end else if (w_accept) begin
      r_dp.act  <= w_ok;
      r_dp.wr   <= bus.HWRITE;
      r_dp.size <= bus.HSIZE[1:0];
      r_dp.lane <= bus.HADDR[1:0];
      r_widx    <= w_off[AW+1:2];
    end else if (w_done) begin
      r_dp.act <= 1'b0;
    end
  end

  assign w_we = {4{w_done && r_dp.wr}} & byte_en(r_dp.size, r_dp.lane);

  ahb_sram_array #(.NUM_WORDS(MEM_WORDS), .NUM_LANES(4)) u_sram (
    .clk     (HCLK),
    .i_we    (w_we),
    .i_waddr (r_widx),
    .i_wdata (bus.HWDATA),
    .i_raddr (r_widx),
    .o_rdata (w_rdata)
  );

  assign bus.HREADYOUT = w_hreadyout;
  assign bus.HRESP     = w_hresp;
  assign bus.HRDATA    = (w_done && !r_dp.wr) ? w_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Randomized + directed bench: two responders (0 and 3 wait states) driven by
// a cycle-level master and checked against a byte-addressed memory model.
module tb_ahb_lite_sram_slave;

  typedef struct {
    logic        sel;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [31:0] wd;
  } xfer_t;

  localparam int          NW = 256;
  localparam logic [31:0] BASE1 = 32'h0000_1000;
  int          ws_of[2]   = '{0, 3};
  logic [31:0] base_of[2] = '{32'h0, BASE1};

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  logic [1:0]        m_hsel, m_hwrite;
  logic [1:0][31:0]  m_haddr, m_hwdata;
  logic [1:0][2:0]   m_hsize, m_hburst;
  logic [1:0][1:0]   m_htrans;
  logic [1:0]        s_rdy, s_resp;
  logic [1:0][31:0]  s_rdata;

  ahb_lite_if bus0();
  ahb_lite_if bus1();

  assign bus0.HSEL = m_hsel[0];   assign bus1.HSEL = m_hsel[1];
  assign bus0.HADDR = m_haddr[0]; assign bus1.HADDR = m_haddr[1];
  assign bus0.HWRITE = m_hwrite[0]; assign bus1.HWRITE = m_hwrite[1];
  assign bus0.HSIZE = m_hsize[0]; assign bus1.HSIZE = m_hsize[1];
  assign bus0.HBURST = m_hburst[0]; assign bus1.HBURST = m_hburst[1];
  assign bus0.HPROT = 4'h3;       assign bus1.HPROT = 4'h3;
  assign bus0.HTRANS = m_htrans[0]; assign bus1.HTRANS = m_htrans[1];
  assign bus0.HWDATA = m_hwdata[0]; assign bus1.HWDATA = m_hwdata[1];
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus1.HREADY = bus1.HREADYOUT;
  assign s_rdy[0] = bus0.HREADYOUT; assign s_rdy[1] = bus1.HREADYOUT;
  assign s_resp[0] = bus0.HRESP;    assign s_resp[1] = bus1.HRESP;
  assign s_rdata[0] = bus0.HRDATA;  assign s_rdata[1] = bus1.HRDATA;

  ahb_lite_sram_slave #(.MEM_WORDS(NW), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0));
  ahb_lite_sram_slave #(.MEM_WORDS(NW), .WAIT_STATES(3), .BASE_ADDR(BASE1)) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1));

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] mdl [2][NW];
  xfer_t tq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic xfer_t mk(logic sel, logic wr, logic [31:0] addr, logic [2:0] size,
                               logic [1:0] trans, logic [31:0] wd);
    xfer_t t;
    t.sel = sel; t.wr = wr; t.addr = addr; t.size = size; t.trans = trans; t.wd = wd;
    return t;
  endfunction

  function automatic logic active(xfer_t t);
    return t.sel && (t.trans == 2'd2 || t.trans == 2'd3);
  endfunction

  // Spec-level legality: in range, size <= word, naturally aligned.
  function automatic logic is_err(int d, xfer_t t);
    logic [31:0] off;
    int nb;
    off = t.addr - base_of[d];
    nb = 1 << t.size;
    if (!active(t)) return 1'b0;
    if (t.size > 3'd2) return 1'b1;
    if (off >= 32'(4 * NW)) return 1'b1;
    return (t.addr % nb) != 0;
  endfunction

  task automatic mdl_write(int d, xfer_t t);
    int idx, ln;
    idx = int'((t.addr - base_of[d]) / 4);
    for (int i = 0; i < (1 << t.size); i++) begin
      ln = int'(t.addr % 4) + i;
      mdl[d][idx][8*ln +: 8] = t.wd[8*ln +: 8];
    end
  endtask

  // Plays tq back-to-back on bus d; every data phase is checked on completion.
  task automatic run(input int d, output int cyc);
    xfer_t prev, cur, idle_x;
    logic  perr, pact;
    int    lows, expw;
    logic [31:0] exp_rd;
    idle_x = mk(0, 0, 0, 0, 2'd0, 0);
    prev = idle_x;
    cyc = 0;
    for (int k = 0; k <= tq.size(); k++) begin
      cur = (k < tq.size()) ? tq[k] : idle_x;
      m_hsel[d] = cur.sel; m_hwrite[d] = cur.wr; m_haddr[d] = cur.addr;
      m_hsize[d] = cur.size; m_htrans[d] = cur.trans; m_hburst[d] = 3'd1;
      m_hwdata[d] = prev.wd;
      perr = is_err(d, prev);
      pact = active(prev) && !perr;
      expw = perr ? 1 : (pact ? ws_of[d] : 0);
      lows = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge HCLK);
        if (s_rdy[d]) break;
        lows++;
        chk("low_resp", 32'(s_resp[d]), 32'(perr));
        chk("low_rdata", s_rdata[d], 32'h0);
        @(posedge HCLK); #1;
        cyc++;
      end
      chk("waits", lows, expw);
      chk("resp", 32'(s_resp[d]), 32'(perr));
      exp_rd = (pact && !prev.wr) ? mdl[d][int'((prev.addr - base_of[d]) / 4)] : 32'h0;
      chk("rdata", s_rdata[d], exp_rd);
      if (pact && prev.wr) mdl_write(d, prev);
      @(posedge HCLK); #1;
      cyc++;
      prev = cur;
    end
    tq.delete();
  endtask

  function automatic xfer_t rnd_x(int d);
    xfer_t t;
    logic [31:0] off;
    int r;
    t.sel = ($urandom_range(0, 99) < 92);
    r = $urandom_range(0, 9);
    t.trans = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : {1'b1, 1'($urandom_range(0, 1))};
    t.wr = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 9);
    t.size = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
    r = $urandom_range(0, 9);
    if (r == 0)      off = 32'h400 + $urandom_range(0, 15);
    else if (r == 1) off = 32'hFFFF_FFFC;
    else             off = $urandom_range(0, 127);
    if ($urandom_range(0, 7) != 0 && t.size <= 3'd2)
      off = off & ~((32'd1 << t.size) - 32'd1);
    t.addr = base_of[d] + off;
    t.wd = $urandom;
    return t;
  endfunction

  initial begin
    int cyc;
    logic [31:0] b;
    m_hsel = '0; m_hwrite = '0; m_haddr = '0; m_hsize = '0; m_hburst = '0;
    m_htrans = '0; m_hwdata = '0;
    #3;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdy", 32'(s_rdy[d]), 32'h1);
      chk("rst_resp", 32'(s_resp[d]), 32'h0);
      chk("rst_rdata", s_rdata[d], 32'h0);
    end
    #10 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Known contents for the first 32 words of both memories.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++)
        tq.push_back(mk(1, 1, base_of[d] + 32'(4 * i), 3'd2, 2'd2, 32'h0101_0101 * i));
      run(d, cyc);
    end

    // Zero-wait directed traffic.
    tq.push_back(mk(1, 1, 32'h10, 3'd2, 2'd2, 32'hDEAD_BEEF));
    tq.push_back(mk(1, 0, 32'h10, 3'd2, 2'd2, 0));
    tq.push_back(mk(1, 1, 32'h20, 3'd0, 2'd2, 32'h0000_0011));
    tq.push_back(mk(1, 1, 32'h21, 3'd0, 2'd2, 32'h0000_2200));
    tq.push_back(mk(1, 1, 32'h22, 3'd0, 2'd2, 32'h0033_0000));
    tq.push_back(mk(1, 1, 32'h23, 3'd0, 2'd2, 32'h4400_0000));
    tq.push_back(mk(1, 0, 32'h20, 3'd2, 2'd2, 0));
    tq.push_back(mk(1, 1, 32'h22, 3'd1, 2'd2, 32'hABCD_0000));
    tq.push_back(mk(1, 0, 32'h20, 3'd2, 2'd2, 0));
    tq.push_back(mk(1, 0, 32'h401, 3'd2, 2'd2, 0));
    tq.push_back(mk(1, 0, 32'h400, 3'd2, 2'd2, 0));
    tq.push_back(mk(1, 1, 32'h12, 3'd2, 2'd2, 32'h5555_5555));
    tq.push_back(mk(1, 0, 32'h10, 3'd2, 2'd2, 0));
    tq.push_back(mk(1, 0, 32'h10, 3'd3, 2'd2, 0));
    tq.push_back(mk(1, 1, 32'h10, 3'd2, 2'd0, 32'h1111_1111));
    tq.push_back(mk(1, 1, 32'h10, 3'd2, 2'd1, 32'h2222_2222));
    tq.push_back(mk(0, 1, 32'h10, 3'd2, 2'd2, 32'h3333_3333));
    tq.push_back(mk(1, 0, 32'h10, 3'd2, 2'd2, 0));
    run(0, cyc);
    chk("bytes_word", mdl[0][8], 32'hABCD_2211);
    chk("dut0_cycles", cyc, 19 + 2 + 1 + 1);

    // Wait-state responder: single read, 4-beat INCR burst, errors.
    tq.push_back(mk(1, 0, BASE1 + 32'h10, 3'd2, 2'd2, 0));
    run(1, cyc);
    chk("single_cyc", cyc, 1 + 4);
    for (int i = 0; i < 4; i++)
      tq.push_back(mk(1, 1, BASE1 + 32'h40 + 32'(4 * i), 3'd2, (i == 0) ? 2'd2 : 2'd3,
                      32'hA5A5_0000 + i));
    run(1, cyc);
    chk("burst_cyc", cyc, 1 + 16);
    for (int i = 0; i < 4; i++)
      tq.push_back(mk(1, 0, BASE1 + 32'h40 + 32'(4 * i), 3'd2, (i == 0) ? 2'd2 : 2'd3, 0));
    tq.push_back(mk(1, 0, BASE1 + 32'h400, 3'd2, 2'd2, 0));
    tq.push_back(mk(1, 0, BASE1 - 32'h4, 3'd2, 2'd2, 0));
    tq.push_back(mk(1, 1, BASE1 + 32'h42, 3'd2, 2'd2, 32'hFFFF_FFFF));
    tq.push_back(mk(1, 0, BASE1 + 32'h40, 3'd2, 2'd2, 0));
    run(1, cyc);

    // Randomized traffic on both responders.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 200; i++) tq.push_back(rnd_x(d));
      run(d, cyc);
    end

    // Reset asserted while a write sits in wait states: the write is dropped.
    b = mdl[1][16];
    m_hsel[1] = 1; m_hwrite[1] = 1; m_haddr[1] = BASE1 + 32'h40; m_hsize[1] = 3'd2;
    m_htrans[1] = 2'd2;
    @(posedge HCLK); #1;
    m_htrans[1] = 2'd0; m_hsel[1] = 0; m_hwdata[1] = 32'hCAFE_F00D;
    chk("wait_rdy", 32'(s_rdy[1]), 32'h0);
    @(posedge HCLK); #2;
    HRESETn = 1'b0;
    #1;
    chk("arst_rdy", 32'(s_rdy[1]), 32'h1);
    chk("arst_resp", 32'(s_resp[1]), 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    tq.push_back(mk(1, 0, BASE1 + 32'h40, 3'd2, 2'd2, 0));
    run(1, cyc);
    chk("arst_mdl", mdl[1][16], b);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
